// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage radix-2 restoring divider:
// FSM state encodings and the result-width helper.
package div_unit_pkg;

  // FSM encodings, kept as plain constants so legacy code can compare raw bits.
  localparam logic [1:0] DIV_FREE    = 2'd0;
  localparam logic [1:0] DIV_BY_ZERO = 2'd1;
  localparam logic [1:0] DIV_ON      = 2'd2;
  localparam logic [1:0] DIV_END     = 2'd3;

  typedef logic [1:0] divState_t;

  // The result packs {remainder, quotient}, so it is twice the operand width.
  function automatic int divResultWidth(input int dataW);
    return 2 * dataW;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Pipeline-side connection of the divider: request, operands, flush/stall controls and result.
interface div_unit_if #(
  parameter int DATA_W = 32
) ();
  import div_unit_pkg::*;

  // Handshake: the EX stage raises start_i (isdivE & ~ready_o) and keeps the
  // operands on the bus; only the cycle in which the divider is idle samples
  // them. ready_o marks the cycle(s) where result_o is valid; it is a
  // registered flag, stays high while hold_i is set, and drops the cycle after
  // hold_i is released. annul_i overrides everything and discards the operation.
  logic                              start_i;
  logic                              signed_i;
  logic [DATA_W-1:0]                 opa_i;
  logic [DATA_W-1:0]                 opb_i;
  logic                              annul_i;
  logic                              hold_i;
  logic [divResultWidth(DATA_W)-1:0] result_o;
  logic                              ready_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i, hold_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i, hold_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor, keep the difference if it did not borrow.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   remIn,
  input  logic [DATA_W-1:0] quoIn,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   remOut,
  output logic [DATA_W-1:0] quoOut
);

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;
  logic              borrow;

  always_comb begin
    shifted = {remIn, quoIn[DATA_W-1]};
    diff    = shifted - {2'b00, divisor};
    borrow  = diff[DATA_W+1];
    remOut  = borrow ? shifted[DATA_W:0] : diff[DATA_W:0];
    quoOut  = {quoIn[DATA_W-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; flushable by exceptions and held by downstream stalls.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus,
  output divState_t  dbgState
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  divState_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W:0]       rem;
  logic [DATA_W:0]       remNext;
  logic [DATA_W-1:0]     quo;
  logic [DATA_W-1:0]     quoNext;
  logic [DATA_W-1:0]     divisor;
  logic                  signA;
  logic                  signB;
  logic [2*DATA_W-1:0]   resultQ;
  logic [DATA_W-1:0]     absOpA;
  logic [DATA_W-1:0]     absOpB;
  logic                  divZero;
  logic                  lastStep;

  // Two's-complement negate when requested; used for abs on entry and fix-up on exit.
  function automatic logic [DATA_W-1:0] condNeg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  always_comb begin
    absOpA   = condNeg(bus.signed_i & bus.opa_i[DATA_W-1], bus.opa_i);
    absOpB   = condNeg(bus.signed_i & bus.opb_i[DATA_W-1], bus.opb_i);
    divZero  = (bus.opb_i == '0);
    lastStep = (state == DIV_ON) && (cnt == LAST_CNT);
  end

  div_unit_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .remIn   (rem),
    .quoIn   (quo),
    .divisor (divisor),
    .remOut  (remNext),
    .quoOut  (quoNext)
  );

  // Control FSM; annul_i wins over every other condition, including a fresh start_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
    end else if (bus.annul_i) begin
      state <= DIV_FREE;
    end else begin
      case (state)
        DIV_FREE: begin
          if (bus.start_i) state <= divZero ? DIV_BY_ZERO : DIV_ON;
        end
        DIV_BY_ZERO: state <= DIV_END;
        DIV_ON: begin
          if (lastStep) state <= DIV_END;
        end
        DIV_END: begin
          if (!bus.hold_i) state <= DIV_FREE;
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

  // Datapath: operands are captured only on acceptance, so later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      resultQ <= '0;
    end else if (bus.annul_i) begin
      cnt <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          if (bus.start_i) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= absOpA;
            divisor <= absOpB;
            signA   <= bus.signed_i & bus.opa_i[DATA_W-1];
            signB   <= bus.signed_i & bus.opb_i[DATA_W-1];
          end
        end
        DIV_ON: begin
          rem <= remNext;
          quo <= quoNext;
          cnt <= cnt + CNT_W'(1);
          // Quotient sign is the XOR of operand signs; remainder follows the dividend.
          if (lastStep) begin
            resultQ <= {condNeg(signA, remNext[DATA_W-1:0]), condNeg(signA ^ signB, quoNext)};
          end
        end
        DIV_BY_ZERO: begin
          // quo still holds |dividend|; re-applying its sign restores the original operand.
          resultQ <= {condNeg(signA, quo), {DATA_W{1'b1}}};
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = (state == DIV_END);
  assign bus.result_o = resultQ;
  assign dbgState     = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference
// model, covering latency, sign rules, divide-by-zero, annul, hold and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  divState_t     dbgState;
  int            nCmp  = 0;
  int            nFail = 0;
  logic [2*W-1:0] exp_q[$];

  div_unit_if #(.DATA_W(W)) bus ();

  div_unit #(
    .DATA_W (W),
    .CNT_W  (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard comparison
  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer division semantics of DIV/DIVU.
  function automatic logic [2*W-1:0] refDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int          sa;
    int          sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
    return {r, q};
  endfunction

  // Driver: issue one divide, stall like the hazard unit, check latency/result/hold.
  task automatic runDiv(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int holdCycles);
    int             lat;
    int             expLat;
    logic [2*W-1:0] expRes;
    logic [2*W-1:0] got;
    exp_q.push_back(refDiv(sgn, a, b));
    expLat       = (b == 0) ? 2 : 33;
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.opa_i    = a;
    bus.opb_i    = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.ready_o) begin
        bus.opa_i    = $urandom;
        bus.opb_i    = $urandom;
        bus.signed_i = 1'($urandom_range(0, 1));
      end
    end while (!bus.ready_o && lat < 100);
    bus.start_i = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(expLat));
    expRes = exp_q.pop_front();
    got    = bus.result_o;
    check({tag, "_result"}, got, expRes);
    bus.hold_i = (holdCycles > 0);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d_ready", tag, i), 64'(bus.ready_o), 64'(1));
      check($sformatf("%s_hold%0d_result", tag, i), bus.result_o, expRes);
    end
    bus.hold_i = 1'b0;
    @(negedge clk);
    check({tag, "_ready_drop"}, 64'(bus.ready_o), 64'(0));
  endtask

  initial begin
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] lastRes;
    int             kind;
    logic           seenReady;

    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    bus.annul_i  = 1'b0;
    bus.hold_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'(0));
    check("reset_result", bus.result_o, 64'(0));
    check("reset_state", 64'(dbgState), 64'(DIV_FREE));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    check("divu_100_7_exact", bus.result_o, {32'd2, 32'd14});
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2_exact", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_exact", bus.result_o, {32'd0, 32'h8000_0000});
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 0);
    check("divu_5_0_exact", bus.result_o, {32'd5, 32'hFFFF_FFFF});
    runDiv("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    runDiv("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 0);
    runDiv("hold3", 1'b0, 32'd1000, 32'd33, 3);

    // annul at cycle 10 of a division
    lastRes      = bus.result_o;
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.opa_i    = 32'd500;
    bus.opb_i    = 32'd9;
    repeat (10) @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_state", 64'(dbgState), 64'(DIV_FREE));
    seenReady = bus.ready_o;
    repeat (40) begin
      @(negedge clk);
      seenReady = seenReady | bus.ready_o;
    end
    check("annul_no_ready", 64'(seenReady), 64'(0));
    check("annul_result_held", bus.result_o, lastRes);
    runDiv("after_annul", 1'b1, 32'hFFFF_FC18, 32'd7, 0);

    // annul together with start in IDLE: the start is dropped
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.opb_i   = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    check("annul_with_start_state", 64'(dbgState), 64'(DIV_FREE));
    @(negedge clk);
    check("annul_with_start_ready", 64'(bus.ready_o), 64'(0));

    // reset in the middle of a division
    bus.start_i = 1'b1;
    bus.opa_i   = 32'd77;
    bus.opb_i   = 32'd5;
    repeat (15) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.ready_o), 64'(0));
    check("midrst_result", bus.result_o, 64'(0));
    check("midrst_state", 64'(dbgState), 64'(DIV_FREE));
    rst = 1'b0;
    @(negedge clk);

    // Randomized back-to-back divides
    for (int i = 0; i < 24; i++) begin
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = W'(0) - W'($urandom_range(1, 15));
        3: b = $urandom >> $urandom_range(0, 31);
        4: begin
          a = 32'h8000_0000;
          b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1;
        end
        default: b = $urandom;
      endcase
      runDiv($sformatf("rand%0d", i), sgn, a, b, $urandom_range(0, 2));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
